// File: rtl/pin_arb_pkg.sv
// Shared definitions for the PIN verifier arbiter: session FSM encoding, digit width
// and counter-width helpers.
package pin_arb_pkg;

   typedef enum logic [2:0] {
      INICIO  = 3'd0,
      INICIAR = 3'd1,
      DIGITOS = 3'd2,
      ESPERA  = 3'd3,
      INFORME = 3'd4
   } state_t;

   localparam int DIG_W = 4;

   // Bits needed to hold the value max_val itself.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Bits needed to index n items.
   function automatic int idx_w(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pin_access_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr+1, wrapping modulo N.
module rr_arbiter
   import pin_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          req_i,
   input  logic [idx_w(N)-1:0]   ptr_i,
   output logic [N-1:0]          gnt_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i == (int'(ptr_i) + k) % N)) begin
               gnt_o[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pin_access_arbiter.sv
// Shares one PIN verifier among N_EST keypad stations with per-session round-robin grant,
// forced-denial timeout and per-station failure lockout.
//   state   | meaning
//   INICIO  | idle, pick next eligible station
//   INICIAR | session start pulse to verifier
//   DIGITOS | forward granted station's digits
//   ESPERA  | wait for verifier verdict
//   INFORME | result pulse to owner, release grant
module pin_access_arbiter
   import pin_arb_pkg::*;
#(
   parameter int N_EST      = 4,
   parameter int N_DIG      = 4,
   parameter int TIMEOUT    = 64,
   parameter int MAX_FALLOS = 3,
   parameter int BLOQUEO    = 256
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [N_EST-1:0]         sol_i,
   input  logic [N_EST-1:0]         dig_stb_in_i,
   input  logic [DIG_W*N_EST-1:0]   dig_in_i,
   output logic [N_EST-1:0]         grant_o,
   output logic [N_EST-1:0]         aceptado_o,
   output logic [N_EST-1:0]         denegado_o,
   output logic [N_EST-1:0]         bloqueado_o,
   output logic                     v_solicitud_o,
   output logic                     v_digito_stb_o,
   output logic [DIG_W-1:0]         v_digito_o,
   input  logic                     v_aceptado_i,
   input  logic                     v_denegado_i
);

   localparam int PW  = idx_w(N_EST);
   localparam int DCW = cnt_w(N_DIG);
   localparam int TW  = cnt_w(TIMEOUT);
   localparam int FW  = cnt_w(MAX_FALLOS);
   localparam int LW  = cnt_w(BLOQUEO);

   state_t             state_q;
   logic [N_EST-1:0]   grant_q, aceptado_q, denegado_q, bloqueado_q;
   logic [PW-1:0]      ptr_q;
   logic [DCW-1:0]     dcnt_q;
   logic [TW-1:0]      tmr_q;
   logic [FW-1:0]      fail_q [N_EST];
   logic [LW-1:0]      lock_q [N_EST];
   logic               v_sol_q, v_stb_q;
   logic [DIG_W-1:0]   v_dig_q;

   logic [N_EST-1:0]   elig_d, arb_gnt_d;
   logic [PW-1:0]      gidx_d;
   logic               stb_d;
   logic [DIG_W-1:0]   dig_d;
   logic               fin_d, acc_d;

   assign elig_d = sol_i & ~bloqueado_q;

   rr_arbiter #(.N(N_EST)) u_rr (
      .req_i (elig_d),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt_d)
   );

   always_comb begin
      gidx_d = '0;
      stb_d  = 1'b0;
      dig_d  = '0;
      for (int i = 0; i < N_EST; i++) begin
         if (grant_q[i]) begin
            gidx_d = PW'(i);
            stb_d  = dig_stb_in_i[i];
            dig_d  = dig_in_i[i*DIG_W +: DIG_W];
         end
      end
   end

   // A verifier verdict takes priority over an expiring timer; both flags high means deny.
   always_comb begin
      fin_d = ((state_q == DIGITOS) || (state_q == ESPERA)) &&
              (v_aceptado_i || v_denegado_i || (tmr_q == '0));
      acc_d = v_aceptado_i && !v_denegado_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= INICIO;
         grant_q     <= '0;
         aceptado_q  <= '0;
         denegado_q  <= '0;
         bloqueado_q <= '0;
         ptr_q       <= '0;
         dcnt_q      <= '0;
         tmr_q       <= '0;
         v_sol_q     <= 1'b0;
         v_stb_q     <= 1'b0;
         v_dig_q     <= '0;
         for (int i = 0; i < N_EST; i++) begin
            fail_q[i] <= '0;
            lock_q[i] <= '0;
         end
      end else begin
         v_sol_q    <= 1'b0;
         v_stb_q    <= 1'b0;
         aceptado_q <= '0;
         denegado_q <= '0;

         for (int i = 0; i < N_EST; i++) begin
            if (bloqueado_q[i]) begin
               lock_q[i] <= lock_q[i] - LW'(1);
               if (lock_q[i] == LW'(1)) bloqueado_q[i] <= 1'b0;
            end
         end

         case (state_q)
            INICIO: begin
               if (|elig_d) begin
                  grant_q <= arb_gnt_d;
                  v_sol_q <= 1'b1;
                  state_q <= INICIAR;
               end
            end
            INICIAR: begin
               dcnt_q  <= '0;
               tmr_q   <= TW'(TIMEOUT - 1);
               state_q <= DIGITOS;
            end
            DIGITOS, ESPERA: begin
               if (fin_d) begin
                  state_q    <= INFORME;
                  aceptado_q <= acc_d ? grant_q : '0;
                  denegado_q <= acc_d ? '0 : grant_q;
                  for (int i = 0; i < N_EST; i++) begin
                     if (grant_q[i]) begin
                        if (acc_d) begin
                           fail_q[i] <= '0;
                        end else if (fail_q[i] >= FW'(MAX_FALLOS - 1)) begin
                           fail_q[i]      <= '0;
                           bloqueado_q[i] <= 1'b1;
                           lock_q[i]      <= LW'(BLOQUEO);
                        end else begin
                           fail_q[i] <= fail_q[i] + FW'(1);
                        end
                     end
                  end
               end else begin
                  tmr_q <= tmr_q - TW'(1);
                  if ((state_q == DIGITOS) && stb_d) begin
                     v_stb_q <= 1'b1;
                     v_dig_q <= dig_d;
                     dcnt_q  <= dcnt_q + DCW'(1);
                     if (dcnt_q == DCW'(N_DIG - 1)) state_q <= ESPERA;
                  end
               end
            end
            INFORME: begin
               grant_q <= '0;
               ptr_q   <= gidx_d;
               state_q <= INICIO;
            end
            default: state_q <= INICIO;
         endcase
      end
   end

   assign grant_o        = grant_q;
   assign aceptado_o     = aceptado_q;
   assign denegado_o     = denegado_q;
   assign bloqueado_o    = bloqueado_q;
   assign v_solicitud_o  = v_sol_q;
   assign v_digito_stb_o = v_stb_q;
   assign v_digito_o     = v_dig_q;

endmodule

// File: tb/tb_pin_access_arbiter.sv
// Directed bench for pin_access_arbiter; the external verifier accepts the sequence 6,9,6,9.
module tb_pin_access_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sol, dig_stb;
   logic [15:0] dig;
   logic [3:0]  grant, acc, den, bloq;
   logic        v_sol, v_stb;
   logic [3:0]  v_dig;
   logic        v_acc, v_den;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pin_access_arbiter #(
      .N_EST(4), .N_DIG(4), .TIMEOUT(64), .MAX_FALLOS(3), .BLOQUEO(256)
   ) dut (
      .clk_i          (clk),
      .reset_i        (rst),
      .sol_i          (sol),
      .dig_stb_in_i   (dig_stb),
      .dig_in_i       (dig),
      .grant_o        (grant),
      .aceptado_o     (acc),
      .denegado_o     (den),
      .bloqueado_o    (bloq),
      .v_solicitud_o  (v_sol),
      .v_digito_stb_o (v_stb),
      .v_digito_o     (v_dig),
      .v_aceptado_i   (v_acc),
      .v_denegado_i   (v_den)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one session for station s; noise_st >= 0 strobes that station before every digit.
   task automatic session(input int s, input logic [15:0] pin, input int noise_st, input bit both,
                          output logic [3:0] g_obs, output logic sol_pulse, output logic sol_after,
                          output int nstb, output logic [15:0] v_seq, output int leak,
                          output logic [3:0] acc_obs, output logic [3:0] den_obs,
                          output logic [3:0] bloq_obs, output logic [3:0] g_after,
                          output logic [3:0] pulse_after);
      int n;
      logic [3:0] d;
      g_obs = '0; sol_pulse = 1'b0; sol_after = 1'b0; nstb = 0; v_seq = '0; leak = 0;
      acc_obs = '0; den_obs = '0; bloq_obs = '0; g_after = '0; pulse_after = '0;
      n = 0;
      while (grant == 4'b0 && n < 10) begin tick(); n++; end
      g_obs = grant;
      sol_pulse = v_sol;
      if (grant == 4'b0) return;
      tick();
      sol_after = v_sol;
      for (int k = 0; k < 4; k++) begin
         if (noise_st >= 0) begin
            dig_stb = 4'b0001 << noise_st; dig = 16'h5555;
            tick();
            dig_stb = '0;
            if (v_stb) leak++;
         end
         d = pin[15-4*k -: 4];
         dig_stb = 4'b0001 << s; dig = {12'b0, d} << (4*s);
         tick();
         dig_stb = '0;
         if (v_stb) begin nstb++; v_seq = {v_seq[11:0], v_dig}; end
      end
      if (both) begin v_acc = 1'b1; v_den = 1'b1; end
      else if (v_seq == 16'h6969) v_acc = 1'b1;
      else v_den = 1'b1;
      tick();
      v_acc = 1'b0; v_den = 1'b0;
      acc_obs = acc; den_obs = den; bloq_obs = bloq;
      tick();
      g_after = grant;
      pulse_after = acc | den;
   endtask

   logic [3:0]  g_obs, acc_obs, den_obs, bloq_obs, g_after, pulse_after;
   logic        sol_pulse, sol_after;
   int          nstb, leak;
   logic [15:0] v_seq;

   task automatic test_reset();
      rst = 1'b1; sol = '0; dig_stb = '0; dig = '0; v_acc = 1'b0; v_den = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();
      checks++; if ({grant, acc, den, bloq} !== 16'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0000", {grant, acc, den, bloq}); end
      checks++; if ({v_sol, v_stb, v_dig} !== 6'b0) begin errors++; $display("FAIL reset_vout got=%b exp=000000", {v_sol, v_stb, v_dig}); end
   endtask

   task automatic test_single();
      sol = 4'b0001;
      session(0, 16'h6969, -1, 1'b0, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
      sol = '0;
      checks++; if (g_obs !== 4'b0001) begin errors++; $display("FAIL t1_grant got=%b exp=0001", g_obs); end
      checks++; if ({sol_pulse, sol_after} !== 2'b10) begin errors++; $display("FAIL t1_vsol_pulse got=%b exp=10", {sol_pulse, sol_after}); end
      checks++; if (nstb !== 4) begin errors++; $display("FAIL t1_nstb got=%0d exp=4", nstb); end
      checks++; if (v_seq !== 16'h6969) begin errors++; $display("FAIL t1_digits got=%h exp=6969", v_seq); end
      checks++; if ({acc_obs, den_obs} !== 8'b0001_0000) begin errors++; $display("FAIL t1_result got=%b exp=00010000", {acc_obs, den_obs}); end
      checks++; if ({g_after, pulse_after} !== 8'b0) begin errors++; $display("FAIL t1_release got=%b exp=00000000", {g_after, pulse_after}); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [3];
      exp_g[0] = 4'b0100; exp_g[1] = 4'b0001; exp_g[2] = 4'b0100;
      sol = 4'b0101;
      for (int r = 0; r < 3; r++) begin
         session((exp_g[r] == 4'b0100) ? 2 : 0, 16'h6969, 1, 1'b0, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
         checks++; if (g_obs !== exp_g[r]) begin errors++; $display("FAIL t2_grant%0d got=%b exp=%b", r, g_obs, exp_g[r]); end
         checks++; if (leak !== 0 || nstb !== 4) begin errors++; $display("FAIL t2_leak%0d got leak=%0d nstb=%0d exp leak=0 nstb=4", r, leak, nstb); end
         checks++; if (acc_obs !== exp_g[r]) begin errors++; $display("FAIL t2_acc%0d got=%b exp=%b", r, acc_obs, exp_g[r]); end
      end
      sol = '0;
   endtask

   task automatic test_lockout();
      int cnt;
      logic granted;
      sol = 4'b0100;
      for (int r = 0; r < 3; r++) begin
         session(2, 16'h3969, -1, 1'b0, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
         checks++; if ({acc_obs, den_obs} !== 8'b0000_0100) begin errors++; $display("FAIL t3_deny%0d got=%b exp=00000100", r, {acc_obs, den_obs}); end
         checks++; if (bloq_obs !== ((r == 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL t3_bloq%0d got=%b", r, bloq_obs); end
      end
      cnt = 1; granted = 1'b0;
      while (bloq[2] && cnt < 400) begin
         if (grant != 4'b0) granted = 1'b1;
         cnt++;
         tick();
      end
      checks++; if (cnt !== 256) begin errors++; $display("FAIL t3_lock_len got=%0d exp=256", cnt); end
      checks++; if (granted !== 1'b0) begin errors++; $display("FAIL t3_grant_while_locked got=%b exp=0", granted); end
      tick();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL t3_regrant got=%b exp=0100", grant); end
      session(2, 16'h6969, -1, 1'b0, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
      sol = '0;
      checks++; if (acc_obs !== 4'b0100) begin errors++; $display("FAIL t3_accept_after got=%b exp=0100", acc_obs); end
   endtask

   task automatic test_timeout();
      int n;
      sol = 4'b0010;
      n = 0;
      while (grant == 4'b0 && n < 10) begin tick(); n++; end
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t4_grant got=%b exp=0010", grant); end
      tick();
      dig_stb = 4'b0010; dig = 16'h0060;
      tick();
      dig = 16'h0090;
      tick();
      dig_stb = '0;
      n = 2;
      while (den == 4'b0 && n < 100) begin tick(); n++; end
      checks++; if (n !== 64) begin errors++; $display("FAIL t4_timeout_cycle got=%0d exp=64", n); end
      checks++; if ({acc, den} !== 8'b0000_0010) begin errors++; $display("FAIL t4_deny got=%b exp=00000010", {acc, den}); end
      tick();
      checks++; if (grant !== 4'b0) begin errors++; $display("FAIL t4_release got=%b exp=0000", grant); end
      session(1, 16'h3969, -1, 1'b0, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
      checks++; if ({den_obs, bloq_obs} !== 8'b0010_0000) begin errors++; $display("FAIL t4_second_deny got=%b exp=00100000", {den_obs, bloq_obs}); end
      session(1, 16'h3969, -1, 1'b0, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
      sol = '0;
      checks++; if ({den_obs, bloq_obs} !== 8'b0010_0010) begin errors++; $display("FAIL t4_third_lock got=%b exp=00100010", {den_obs, bloq_obs}); end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [3:0] seen;
      sol = 4'b0001;
      n = 0;
      while (grant == 4'b0 && n < 10) begin tick(); n++; end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t5_grant got=%b exp=0001", grant); end
      tick();
      sol = '0;
      for (int k = 0; k < 4; k++) begin
         dig_stb = 4'b0001; dig = (k % 2 == 0) ? 16'h0006 : 16'h0009;
         tick();
      end
      dig_stb = '0;
      tick();
      checks++; if (bloq !== 4'b0010) begin errors++; $display("FAIL t5_prelock got=%b exp=0010", bloq); end
      rst = 1'b1;
      #1;
      checks++; if ({grant, acc, den, bloq} !== 16'h0) begin errors++; $display("FAIL t5_async_flags got=%h exp=0000", {grant, acc, den, bloq}); end
      checks++; if ({v_sol, v_stb, v_dig} !== 6'b0) begin errors++; $display("FAIL t5_async_vout got=%b exp=000000", {v_sol, v_stb, v_dig}); end
      #1 rst = 1'b0;
      seen = '0;
      for (int k = 0; k < 3; k++) begin tick(); seen = seen | acc | den | grant; end
      checks++; if (seen !== 4'b0) begin errors++; $display("FAIL t5_no_result got=%b exp=0000", seen); end
      sol = 4'b0011;
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t5_ptr0_grant got=%b exp=0010", grant); end
      session(1, 16'h6969, -1, 1'b0, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
      sol = '0;
      checks++; if (acc_obs !== 4'b0010) begin errors++; $display("FAIL t5_accept got=%b exp=0010", acc_obs); end
   endtask

   task automatic test_both();
      sol = 4'b0001;
      session(0, 16'h6969, -1, 1'b1, g_obs, sol_pulse, sol_after, nstb, v_seq, leak, acc_obs, den_obs, bloq_obs, g_after, pulse_after);
      sol = '0;
      checks++; if ({acc_obs, den_obs} !== 8'b0000_0001) begin errors++; $display("FAIL t6_both got=%b exp=00000001", {acc_obs, den_obs}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_lockout();
      test_timeout();
      test_reset_mid();
      test_both();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
